image_norm_stream: RTL and testbench
====================================

# image_norm_stream

Parametrised per-channel min/max normaliser for AXI-Stream pixel data, for use in the preprocessing front end ahead of the accelerator input buffers. Per-channel min/max statistics are collected over a full frame, delimited by SOF (tuser) and EOF (tlast). At end of frame a sequential divider converts them into fixed-point scale coefficients, and those coefficients normalise the next frame through a 2-stage pipeline with correct backpressure. The block also supports a bypass/width-conversion mode and a coefficient freeze.

## Interface
- NUM_CH, 3, number of channels packed in tdata; channel 0 is in the LSBs.
- DATA_WIDTH, 8, input bits per channel.
- OUT_WIDTH, 8, output bits per channel.
- FRAC_BITS, 16, fraction bits of the scale coefficient.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  gates input acceptance only.
- cfg_mode  in  1  0 = bypass/width-convert, 1 = min/max normalise.
- cfg_freeze  in  1  1 = keep the current coefficients at EOF.
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  pixel.
- s_axis_tuser  in  1  SOF, valid on the first beat of a frame.
- s_axis_tlast  in  1  EOF, valid on the last beat of a frame.
- s_axis_tvalid  in  1;  s_axis_tready  out  1.
- m_axis_tdata  out  NUM_CH*OUT_WIDTH;  m_axis_tuser, m_axis_tlast, m_axis_tvalid  out  1;  m_axis_tready  in  1.
- stat_min, stat_max  out  NUM_CH*DATA_WIDTH  statistics latched at the last EOF.
- coeff_valid  out  1  high once a coefficient set has been loaded.
- busy  out  1  coefficient calculation in progress.

## Operation
- **Running statistics.**
  - Registers run_min (reset to all ones) and run_max (reset to 0) update on every accepted beat.
  - An accepted SOF beat reloads run_min and run_max with that beat's values; it does not compare against the old values.
  - A SOF with no prior EOF restarts the statistics and does not latch anything.
- **EOF beat accepted.**
  - stat_min and stat_max latch the running values including the EOF beat itself.
  - If cfg_freeze = 0, the FSM goes IDLE -> CALC.
  - If cfg_freeze = 1, the FSM stays in IDLE and the coefficients are unchanged.
- **CALC.**
  - A restoring divider processes the channels serially, channel 0 first, one quotient bit per cycle, OUT_WIDTH+FRAC_BITS bits per channel.
  - range = stat_max - stat_min, DATA_WIDTH bits wide. If max < min, range is treated as 0.
  - scale = floor(((2^OUT_WIDTH - 1) << FRAC_BITS) / range), OUT_WIDTH+FRAC_BITS bits wide.
  - range = 0 gives scale = 0.
- **CALC -> LOAD -> IDLE.**
  - LOAD copies all new scale values and stat_min into the active coefficient registers in a single cycle.
  - coeff_valid is set in LOAD and is cleared only by reset.
- **Pixel path, mode 1 with coeff_valid = 1.**
  - Stage 1: diff = x - act_min, clamped to 0 if negative. The active scale is captured alongside diff, so in-flight beats are unaffected by a later LOAD.
  - Stage 2: y = (diff*scale + 2^(FRAC_BITS-1)) >> FRAC_BITS, saturated to 2^OUT_WIDTH - 1.
- **Pixel path, mode 0, or mode 1 with coeff_valid = 0.** Width conversion only:
  - OUT_WIDTH >= DATA_WIDTH: x << (OUT_WIDTH - DATA_WIDTH).
  - Otherwise: x >> (DATA_WIDTH - OUT_WIDTH).
- **Sideband.** tuser and tlast travel with their beat through both stages.
- **Live mode changes.** cfg_mode is sampled at stage 1 per beat. cfg_freeze is sampled at the EOF accept.

## Timing
- **Reset values.**
  - s_axis_tready = 0, m_axis_tvalid = 0.
  - m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0.
  - stat_min = 0, stat_max = 0, coeff_valid = 0, busy = 0.
  - FSM returns to IDLE and pipeline valids are cleared; a reset mid-frame or mid-CALC discards everything.
- **Latency and throughput.** 2 cycles from input accept to m_axis_tvalid; 1 beat/cycle sustained.
- **Pipeline advance.** advance = !v2 || m_axis_tready. Both stages shift together on advance; a bubble entering stage 1 clears v1.
- **Input ready.** s_axis_tready = enable && advance && !busy, asserted independently of s_axis_tvalid.
- **Busy window.**
  - busy rises the cycle after the EOF accept and lasts NUM_CH*(OUT_WIDTH+FRAC_BITS) CALC cycles plus 1 LOAD cycle: 73 cycles with the defaults.
  - During busy, input is stalled while the output stages keep draining.
  - The first beat accepted after busy falls uses the new coefficients.
- **enable low.** Blocks acceptance only; the divider and output drain continue.
- **Output stability.** m_axis_tdata, tuser and tlast are held while m_axis_tvalid && !m_axis_tready.

## Test plan
- **Bypass.** cfg_mode = 0 with defaults, input {0x12,0x34,0x56} -> the same value out 2 cycles later. Repeat with OUT_WIDTH = 10 -> each channel shifted left by 2.
- **Normalisation.** Frame A has channel 0 min 50 / max 150 -> busy for exactly 73 cycles, then coefficient scale = 167116. Frame B channel 0 inputs 150, 100, 50, 30 -> outputs 255, 127, 0, 0 (30 is clamped).
- **Flat frame.** Frame with constant 0x80 -> range 0. Next frame outputs all 0; stat_min = stat_max = 0x80.
- **Backpressure.** Random m_axis_tready at 50 %, 1000 beats -> no loss, no duplication, order preserved, tuser/tlast aligned, and tdata stable while stalled.
- **Freeze and restart.**
  - cfg_freeze = 1 at EOF -> stat_* update, busy never rises, old scale still applied.
  - A SOF mid-frame restarts the statistics.
- **Reset.** Assert rst_n mid-CALC -> all outputs return to their reset values and coeff_valid = 0. The next frame passes through as bypass.

Source files
------------

// File: rtl/image_norm_stream.sv
// image_norm_stream: per-channel min/max normaliser for AXI-Stream pixels.
// Frame statistics feed a serial divider whose scales normalise the next frame.
module image_norm_stream #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int FRAC_BITS  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          cfg_mode,
    input  logic                          cfg_freeze,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [NUM_CH*OUT_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [NUM_CH*DATA_WIDTH-1:0]  stat_min,
    output logic [NUM_CH*DATA_WIDTH-1:0]  stat_max,
    output logic                          coeff_valid,
    output logic                          busy
);

    localparam int QW = OUT_WIDTH + FRAC_BITS;
    localparam int PW = DATA_WIDTH + QW + 1;
    localparam int BW = $clog2(QW);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [QW-1:0] DVD = {{OUT_WIDTH{1'b1}}, {FRAC_BITS{1'b0}}};
    localparam logic [PW-1:0] HALF = PW'(1) << (FRAC_BITS - 1);
    localparam logic [OUT_WIDTH-1:0] OMAX = '1;

    typedef enum logic [1:0] {IDLE, CALC, LOAD} state_t;

    state_t state;
    logic   run;
    logic   v1, v2, u1, l1, norm1;
    logic   advance, accept;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] pix, dif;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] run_min, run_max;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] nxt_min, nxt_max;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] smin, smax, act_min, d1;
    logic [NUM_CH-1:0][QW-1:0]         new_scale, act_scale, scale1;
    logic [NUM_CH-1:0][PW-1:0]         prod, sh;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]  conv, y;

    logic [DATA_WIDTH-1:0] rem, rng;
    logic [DATA_WIDTH:0]   trial;
    logic                  ge;
    logic [QW-1:0]         quo, qnext;
    logic [BW-1:0]         bitc;
    logic [CW-1:0]         ch;

    assign pix           = s_axis_tdata;
    assign stat_min      = smin;
    assign stat_max      = smax;
    assign m_axis_tvalid = v2;
    assign advance       = !v2 || m_axis_tready;
    assign s_axis_tready = run && enable && advance && !busy;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Holds input ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Next running stats, clamped difference against the active minimum
    always_comb begin
        nxt_min = run_min;
        nxt_max = run_max;
        dif     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s_axis_tuser || pix[c] < run_min[c]) nxt_min[c] = pix[c];
            if (s_axis_tuser || pix[c] > run_max[c]) nxt_max[c] = pix[c];
            if (pix[c] > act_min[c]) dif[c] = pix[c] - act_min[c];
        end
    end

    // Running min/max per frame, latched into stat_* on the EOF beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min <= '1;
            run_max <= '0;
            smin    <= '0;
            smax    <= '0;
        end else if (accept) begin
            run_min <= nxt_min;
            run_max <= nxt_max;
            if (s_axis_tlast) begin
                smin <= nxt_min;
                smax <= nxt_max;
            end
        end
    end

    // One restoring-divider step for the channel being computed
    always_comb begin
        rng = '0;
        if (smax[ch] > smin[ch]) rng = smax[ch] - smin[ch];
        trial = {rem, DVD[BW'(QW-1) - bitc]};
        ge    = trial >= {1'b0, rng};
        qnext = {quo[QW-2:0], ge};
    end

    // Coefficient FSM: serial division per channel, then atomic load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            coeff_valid <= 1'b0;
            ch          <= '0;
            bitc        <= '0;
            rem         <= '0;
            quo         <= '0;
            new_scale   <= '0;
            act_scale   <= '0;
            act_min     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && s_axis_tlast && !cfg_freeze) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        ch    <= '0;
                        bitc  <= '0;
                        rem   <= '0;
                        quo   <= '0;
                    end
                end
                CALC: begin
                    if (ge) rem <= DATA_WIDTH'(trial - {1'b0, rng});
                    else    rem <= trial[DATA_WIDTH-1:0];
                    quo <= qnext;
                    if (bitc == BW'(QW-1)) begin
                        new_scale[ch] <= (rng == '0) ? '0 : qnext;
                        bitc <= '0;
                        rem  <= '0;
                        if (ch == CW'(NUM_CH-1)) state <= LOAD;
                        else ch <= ch + CW'(1);
                    end else begin
                        bitc <= bitc + BW'(1);
                    end
                end
                LOAD: begin
                    act_scale   <= new_scale;
                    act_min     <= smin;
                    coeff_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Width conversion of the raw sample carried in stage 1
    for (genvar c = 0; c < NUM_CH; c++) begin : g_conv
        if (OUT_WIDTH >= DATA_WIDTH) begin : g_up
            assign conv[c] = OUT_WIDTH'(d1[c]) << (OUT_WIDTH - DATA_WIDTH);
        end else begin : g_dn
            assign conv[c] = d1[c][DATA_WIDTH-1 -: OUT_WIDTH];
        end
    end

    // Stage-2 fixed-point scale with rounding and saturation
    always_comb begin
        prod = '0;
        sh   = '0;
        y    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c] = PW'(d1[c]) * PW'(scale1[c]) + HALF;
            sh[c]   = prod[c] >> FRAC_BITS;
            if (!norm1)             y[c] = conv[c];
            else if (sh[c] > PW'(OMAX)) y[c] = OMAX;
            else                    y[c] = sh[c][OUT_WIDTH-1:0];
        end
    end

    // Two-stage pixel pipeline that shifts as a unit on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1           <= 1'b0;
            u1           <= 1'b0;
            l1           <= 1'b0;
            norm1        <= 1'b0;
            d1           <= '0;
            scale1       <= '0;
            v2           <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tuser <= 1'b0;
            m_axis_tlast <= 1'b0;
        end else if (advance) begin
            v1 <= accept;
            if (accept) begin
                u1     <= s_axis_tuser;
                l1     <= s_axis_tlast;
                norm1  <= cfg_mode && coeff_valid;
                d1     <= (cfg_mode && coeff_valid) ? dif : pix;
                scale1 <= act_scale;
            end
            v2 <= v1;
            if (v1) begin
                m_axis_tdata <= y;
                m_axis_tuser <= u1;
                m_axis_tlast <= l1;
            end
        end
    end

endmodule

// File: tb/tb_image_norm_stream.sv
// tb_image_norm_stream: directed vectors plus a frame-level reference model.
// Outputs, stats, busy window and coeff_valid are checked every cycle.
module tb_image_norm_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, cfg_mode, cfg_freeze;
    logic [23:0] s_tdata;
    logic        s_tuser, s_tlast, s_tvalid, s_tready;
    logic [23:0] m_tdata;
    logic        m_tuser, m_tlast, m_tvalid, m_tready;
    logic [23:0] stat_min, stat_max;
    logic        coeff_valid, busy;

    logic        tv10, r10, m10_ready;
    logic [29:0] m10_tdata;
    logic        m10_tuser, m10_tlast, m10_tvalid;
    logic [23:0] smin10, smax10;
    logic        cv10, busy10;

    image_norm_stream u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_mode(cfg_mode), .cfg_freeze(cfg_freeze),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser),
        .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .stat_min(stat_min), .stat_max(stat_max),
        .coeff_valid(coeff_valid), .busy(busy)
    );

    image_norm_stream #(.OUT_WIDTH(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_mode(cfg_mode), .cfg_freeze(cfg_freeze),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(tv10),
        .s_axis_tready(r10),
        .m_axis_tdata(m10_tdata), .m_axis_tuser(m10_tuser),
        .m_axis_tlast(m10_tlast), .m_axis_tvalid(m10_tvalid),
        .m_axis_tready(m10_ready),
        .stat_min(smin10), .stat_max(smax10),
        .coeff_valid(cv10), .busy(busy10)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit bp_on  = 0;
    int out_cnt = 0;

    // reference model state
    int     rmin[3], rmax[3], smin_m[3], smax_m[3], amin[3];
    longint asc[3];
    bit     mcv, cv_exp;
    int     busy_left;
    logic [25:0] expq[$];
    logic [23:0] outlog[$];

    bit          hold_v;
    logic [25:0] hold_d;
    logic [23:0] es_min, es_max;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            rmin[c] = 255; rmax[c] = 0;
            smin_m[c] = 0; smax_m[c] = 0;
            amin[c] = 0; asc[c] = 0;
        end
        mcv = 0; cv_exp = 0; busy_left = 0;
        expq.delete();
        hold_v = 0;
    endtask

    task automatic model_accept();
        int x[3];
        int rng;
        longint yv;
        logic [23:0] o;
        for (int c = 0; c < 3; c++) x[c] = int'(s_tdata[c*8 +: 8]);
        for (int c = 0; c < 3; c++) begin
            if (cfg_mode && mcv) begin
                yv = longint'(x[c] - amin[c]);
                if (yv < 0) yv = 0;
                yv = (yv * asc[c] + 32768) / 65536;
                if (yv > 255) yv = 255;
            end else begin
                yv = longint'(x[c]);
            end
            o[c*8 +: 8] = 8'(yv);
        end
        expq.push_back({s_tuser, s_tlast, o});
        for (int c = 0; c < 3; c++) begin
            if (s_tuser) begin
                rmin[c] = x[c]; rmax[c] = x[c];
            end else begin
                if (x[c] < rmin[c]) rmin[c] = x[c];
                if (x[c] > rmax[c]) rmax[c] = x[c];
            end
        end
        if (s_tlast) begin
            for (int c = 0; c < 3; c++) begin
                smin_m[c] = rmin[c]; smax_m[c] = rmax[c];
            end
            if (!cfg_freeze) begin
                for (int c = 0; c < 3; c++) begin
                    rng = (smax_m[c] > smin_m[c]) ? smax_m[c] - smin_m[c] : 0;
                    asc[c] = (rng == 0) ? 0 : (longint'(255) * 65536) / rng;
                    amin[c] = smin_m[c];
                end
                mcv = 1;
                busy_left = 73;
            end
        end
    endtask

    // compare process: every cycle out of reset
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                es_min[c*8 +: 8] = 8'(smin_m[c]);
                es_max[c*8 +: 8] = 8'(smax_m[c]);
            end
            chk("stat_min", stat_min, es_min);
            chk("stat_max", stat_max, es_max);
            chk("busy", busy, busy_left > 0);
            chk("coeff_valid", coeff_valid, cv_exp);
            if (busy_left > 0) chk("tready_in_busy", s_tready, 0);
            if (hold_v) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_data", {m_tuser, m_tlast, m_tdata}, hold_d);
            end
            if (m_tvalid && m_tready) begin
                out_cnt++;
                outlog.push_back(m_tdata);
                if (expq.size() == 0) begin
                    n_tot++;
                    $display("FAIL out_unexpected: got %0h expected none",
                             {m_tuser, m_tlast, m_tdata});
                end else begin
                    chk("out_beat", {m_tuser, m_tlast, m_tdata},
                        expq.pop_front());
                end
            end
            hold_v = m_tvalid && !m_tready;
            hold_d = {m_tuser, m_tlast, m_tdata};
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) cv_exp = 1;
            end
            if (s_tvalid && s_tready) model_accept();
        end
    end

    // output backpressure driver
    initial begin
        m_tready = 1;
        forever begin
            @(posedge clk); #1;
            m_tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [23:0] d, input logic u,
                             input logic l);
        int n;
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) begin
            n_tot++;
            $display("FAIL tready_wait: got timeout expected accept");
        end
        @(posedge clk); #1;
        s_tvalid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || expq.size() != 0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk("idle_reached", n < 3000, 1);
        sync();
    endtask

    task automatic check_reset(input string p);
        chk({p, "_tready"}, s_tready, 0);
        chk({p, "_mvalid"}, m_tvalid, 0);
        chk({p, "_mdata"}, m_tdata, 0);
        chk({p, "_muser"}, m_tuser, 0);
        chk({p, "_mlast"}, m_tlast, 0);
        chk({p, "_smin"}, stat_min, 0);
        chk({p, "_smax"}, stat_max, 0);
        chk({p, "_cv"}, coeff_valid, 0);
        chk({p, "_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        bit seen;
        rst_n = 0; enable = 1; cfg_mode = 0; cfg_freeze = 0;
        s_tdata = 0; s_tuser = 0; s_tlast = 0; s_tvalid = 0;
        tv10 = 0; m10_ready = 1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("rst");
        sync();
        rst_n = 1;
        repeat (2) sync();

        // bypass, 2-cycle latency, 8- and 10-bit outputs
        cfg_mode = 0; cfg_freeze = 1;
        tv10 = 1;
        send_beat(24'h123456, 1, 0);
        tv10 = 0;
        @(negedge clk);
        chk("lat_c1_valid", m_tvalid, 0);
        chk("lat_c1_valid10", m10_tvalid, 0);
        @(negedge clk);
        chk("lat_c2_valid", m_tvalid, 1);
        chk("bypass8", m_tdata, 24'h123456);
        chk("lat_c2_valid10", m10_tvalid, 1);
        chk("bypass10", m10_tdata, {10'h048, 10'h0D0, 10'h158});
        sync();
        send_beat(24'hA0B0C0, 0, 1);
        wait_idle();

        // frame A: learn coefficients
        cfg_mode = 1; cfg_freeze = 0;
        send_beat(24'h000A32, 1, 0);
        send_beat(24'hFF1464, 0, 0);
        send_beat(24'h801E96, 0, 1);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 73);
        chk("cv_after_load", coeff_valid, 1);
        chk("fa_stat_min", stat_min, 24'h000A32);
        chk("fa_stat_max", stat_max, 24'hFF1E96);
        chk("model_scale0", 32'(asc[0]), 167116);
        sync();

        // frame B: normalised by frame A coefficients
        wait_idle();
        outlog.delete();
        send_beat(24'h969696, 1, 0);
        send_beat(24'h646464, 0, 0);
        send_beat(24'h323232, 0, 0);
        send_beat(24'h1E1E1E, 0, 1);
        wait_idle();
        chk("fb_count", outlog.size(), 4);
        chk("fb_150", outlog[0][7:0], 255);
        chk("fb_100", outlog[1][7:0], 127);
        chk("fb_50", outlog[2][7:0], 0);
        chk("fb_30", outlog[3][7:0], 0);

        // flat frame gives zero range
        for (int i = 0; i < 4; i++) send_beat(24'h808080, i == 0, i == 3);
        wait_idle();
        chk("flat_smin", stat_min, 24'h808080);
        chk("flat_smax", stat_max, 24'h808080);
        outlog.delete();
        cfg_freeze = 1;
        send_beat(24'h00FF80, 1, 0);
        send_beat(24'h123456, 0, 0);
        send_beat(24'hFFFFFF, 0, 1);
        wait_idle();
        chk("flat_count", outlog.size(), 3);
        foreach (outlog[i]) chk("flat_out", outlog[i], 0);

        // identity coefficients, then freeze
        cfg_freeze = 0;
        send_beat(24'h000000, 1, 0);
        send_beat(24'hFFFFFF, 0, 1);
        wait_idle();
        cfg_freeze = 1;
        send_beat(24'h646464, 1, 0);
        send_beat(24'h6E6E6E, 0, 1);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        chk("freeze_no_busy", seen, 0);
        chk("freeze_smin", stat_min, 24'h646464);
        chk("freeze_smax", stat_max, 24'h6E6E6E);
        sync();
        outlog.delete();
        send_beat(24'hC8C8C8, 1, 1);
        wait_idle();
        chk("freeze_old_scale", outlog[0], 24'hC8C8C8);

        // SOF mid-frame restarts statistics
        send_beat(24'h050505, 1, 0);
        send_beat(24'hFAFAFA, 0, 0);
        send_beat(24'h646464, 1, 0);
        send_beat(24'h787878, 0, 1);
        wait_idle();
        chk("restart_smin", stat_min, 24'h646464);
        chk("restart_smax", stat_max, 24'h787878);

        // enable gates acceptance
        enable = 0;
        @(negedge clk);
        chk("enable_low", s_tready, 0);
        sync();
        enable = 1;

        // random backpressure, 1000 beats in 50-beat frames
        cfg_freeze = 0;
        bp_on = 1;
        n = out_cnt;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) sync();
            send_beat(24'($urandom), (i % 50) == 0, (i % 50) == 49);
        end
        wait_idle();
        bp_on = 0;
        chk("bp_count", out_cnt - n, 1000);
        chk("bp_queue_empty", expq.size(), 0);

        // reset in the middle of CALC
        send_beat(24'h010203, 1, 0);
        send_beat(24'hF0E0D0, 0, 1);
        repeat (10) @(negedge clk);
        chk("mid_calc_busy", busy, 1);
        @(posedge clk); #2;
        rst_n = 0;
        model_reset();
        #1;
        check_reset("rst_calc");
        sync();
        rst_n = 1;
        repeat (2) sync();
        cfg_mode = 1; cfg_freeze = 1;
        outlog.delete();
        send_beat(24'h102030, 1, 0);
        send_beat(24'h405060, 0, 1);
        wait_idle();
        chk("post_rst_cv", coeff_valid, 0);
        chk("post_rst_b0", outlog[0], 24'h102030);
        chk("post_rst_b1", outlog[1], 24'h405060);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
